// File: rtl/dec_scan_seq.sv
// Select generator for a 2**SEL_W-output decoder: steps sel through 0..2**SEL_W-1 with a programmable dwell.
// Define DEC_SCAN_ONEHOT_EN to add a registered one-hot output aligned with sel.
module dec_scan_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               sweep_done
`ifdef DEC_SCAN_ONEHOT_EN
  ,
  output logic [2**SEL_W-1:0] onehot
`endif
);
  localparam int N = 2**SEL_W;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic               mode;
    logic [DWELL_W-1:0] dwell;
  } cfg_t;

  state_t             state;
  cfg_t               cfg_q;
  logic [DWELL_W-1:0] cnt;
  logic               dwell_last, sel_last, go;

  assign go         = start && !stop;
  assign dwell_last = (cnt == cfg_q.dwell - 1'b1);
  assign sel_last   = (sel == {SEL_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cfg_q      <= '0;
      cnt        <= '0;
      sel        <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state       <= RUN;
          sel         <= '0;
          sel_valid   <= 1'b1;
          busy        <= 1'b1;
          cnt         <= '0;
          cfg_q.mode  <= mode;
          cfg_q.dwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
        end
        RUN: begin
          // stop overrides any sweep completion on the same edge
          if (stop) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else if (!dwell_last) begin
            cnt <= cnt + 1'b1;
          end else if (!sel_last) begin
            sel <= sel + 1'b1;
            cnt <= '0;
          end else begin
            sel        <= '0;
            cnt        <= '0;
            sweep_done <= 1'b1;
            if (cfg_q.mode) begin
              state     <= IDLE;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEC_SCAN_ONEHOT_EN
  logic [SEL_W-1:0] sel_nxt;
  logic             vld_nxt;

  // Next sel/sel_valid, so onehot lands on the same edge as sel
  always_comb begin
    sel_nxt = sel;
    vld_nxt = sel_valid;
    case (state)
      IDLE: if (go) begin
        sel_nxt = '0;
        vld_nxt = 1'b1;
      end
      RUN: begin
        if (stop) begin
          sel_nxt = '0;
          vld_nxt = 1'b0;
        end else if (dwell_last) begin
          if (!sel_last) sel_nxt = sel + 1'b1;
          else begin
            sel_nxt = '0;
            vld_nxt = !cfg_q.mode;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot <= '0;
    else     onehot <= vld_nxt ? (N'(1) << sel_nxt) : '0;
  end
`endif
endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: sweeps, wrap, dwell zero, stop/start priority, async reset.
module tb_dec_scan_seq;
  localparam int SEL_W = 3, DWELL_W = 8;

  logic               clk = 1'b0, rst = 1'b1;
  logic               start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid, busy, sweep_done;
`ifdef DEC_SCAN_ONEHOT_EN
  logic [7:0]         onehot;
`endif

  int total = 0, bad = 0;

  dec_scan_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dwell(dwell),
    .sel(sel), .sel_valid(sel_valid), .busy(busy), .sweep_done(sweep_done)
`ifdef DEC_SCAN_ONEHOT_EN
    , .onehot(onehot)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag, input logic done);
    chk({tag, ".sel"}, 32'(sel), 0);
    chk({tag, ".vld"}, 32'(sel_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(sweep_done), 32'(done));
`ifdef DEC_SCAN_ONEHOT_EN
    chk({tag, ".oh"}, 32'(onehot), 0);
`endif
  endtask

  task automatic kick(input int dw, input logic md);
    dwell = DWELL_W'(dw);
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycle k=1 is the first sample after the start edge; poke pulses start and scrambles mode/dwell mid-run
  task automatic run_check(input string tag, input int dw, input logic md, input int ncyc, input bit poke);
    int dq, len, e_sel;
    logic e_vld, e_done;
    dq  = (dw == 0) ? 1 : dw;
    len = 8 * dq;
    for (int k = 1; k <= ncyc; k++) begin
      start = 1'b0;
      if (md && k > len) begin
        e_vld = 1'b0; e_sel = 0; e_done = (k == len + 1);
      end else begin
        e_vld = 1'b1; e_sel = ((k - 1) / dq) % 8; e_done = (k > 1) && ((k - 1) % len == 0);
      end
      chk($sformatf("%s.sel[%0d]", tag, k), 32'(sel), 32'(e_sel));
      chk($sformatf("%s.vld[%0d]", tag, k), 32'(sel_valid), 32'(e_vld));
      chk($sformatf("%s.busy[%0d]", tag, k), 32'(busy), 32'(e_vld));
      chk($sformatf("%s.done[%0d]", tag, k), 32'(sweep_done), 32'(e_done));
`ifdef DEC_SCAN_ONEHOT_EN
      chk($sformatf("%s.oh[%0d]", tag, k), 32'(onehot), e_vld ? (32'd1 << e_sel) : 32'd0);
`endif
      if (poke && k == 3) begin
        start = 1'b1;
        mode  = ~md;
        dwell = 8'd5;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk_idle("rst_hold", 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk_idle("post_rst", 1'b0);

    kick(2, 1'b1);
    run_check("single", 2, 1'b1, 18, 1'b0);

    kick(1, 1'b0);
    run_check("cont", 1, 1'b0, 20, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("cont_stop", 1'b0);

    kick(0, 1'b1);
    run_check("dw0", 0, 1'b1, 10, 1'b0);

    dwell = 8'd2;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("start_stop", 1'b0);

    // Stop lands on the edge that would finish the sweep (sel=7, last dwell cycle at k=24)
    kick(3, 1'b0);
    run_check("pre_stop", 3, 1'b0, 23, 1'b0);
    chk("stop7.sel", 32'(sel), 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("stop7", 1'b0);
    tick();
    chk_idle("stop7_after", 1'b0);

    kick(2, 1'b1);
    run_check("poke", 2, 1'b1, 18, 1'b1);

    // Async reset mid-scan with sel=5, dwell=4
    kick(4, 1'b0);
    run_check("pre_rst", 4, 1'b0, 22, 1'b0);
    chk("mid.sel", 32'(sel), 5);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst", 1'b0);
    #1 rst = 1'b0;
    tick();
    tick();
    chk_idle("rst_release", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
